// File: rtl/ram_bist_pkg.sv
// Shared types for the RAM March C- BIST: FSM states, march elements and the
// per-element operation table.
package ram_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } bist_state_e;

    typedef enum logic [2:0] {
        EL_M0,
        EL_M1,
        EL_M2,
        EL_M3,
        EL_M4,
        EL_M5
    } march_elem_e;

    typedef struct packed {
        logic down;     // address order descends
        logic rd;       // element reads before any write
        logic wr;       // element writes
        logic exp_inv;  // expected read word is the complemented background
        logic wr_inv;   // written word is the complemented background
    } elem_cfg_t;

    // Indexed by march_elem_e; the two unused encodings are inert.
    localparam elem_cfg_t ELEM_CFG [8] = '{
        '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
        '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1},
        '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
        '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1},
        '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
        '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
        '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0}
    };

    function automatic march_elem_e next_elem(input march_elem_e e);
        case (e)
            EL_M0:   return EL_M1;
            EL_M1:   return EL_M2;
            EL_M2:   return EL_M3;
            EL_M3:   return EL_M4;
            EL_M4:   return EL_M5;
            default: return EL_M0;
        endcase
    endfunction

endpackage

// File: rtl/ram_march_bist_if.sv
// Requester-side port of the single-port synchronous RAM, as driven by the BIST.
interface ram_march_bist_if #(
    parameter int Data_width = 32,
    parameter int Addr_width = 7
);
    logic                  ram_we;
    logic [Addr_width-1:0] ram_address;
    logic [Data_width-1:0] ram_d;
    logic [Data_width-1:0] ram_q;

    modport master (output ram_we, output ram_address, output ram_d, input ram_q);
    modport slave  (input ram_we, input ram_address, input ram_d, output ram_q);
endinterface

// File: rtl/ram_bist_march_seq.sv
// March C- element/address sequencer: drives the RAM port and registers the
// read-compare request (valid, expected word, address) for the cycle after.
module ram_bist_march_seq
    import ram_bist_pkg::*;
#(
    parameter int                    Data_width = 32,
    parameter int                    Addr_width = 7,
    parameter logic [Data_width-1:0] DATA_BG    = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  go_i,
    input  logic                  run_i,
    output logic                  last_o,
    output logic                  cmp_valid_o,
    output logic [Data_width-1:0] cmp_exp_o,
    output logic [Addr_width-1:0] cmp_addr_o,
    ram_march_bist_if.master      ram
);

    localparam logic [Addr_width-1:0] ADDR_MAX = '1;

    march_elem_e           elem_q, elem_d;
    logic [Addr_width-1:0] addr_q, addr_d;
    logic                  cmp_valid_q, cmp_valid_d;
    logic [Data_width-1:0] cmp_exp_q, cmp_exp_d;
    logic [Addr_width-1:0] cmp_addr_q, cmp_addr_d;
    elem_cfg_t             cfg;
    march_elem_e           elem_nxt;
    logic                  elem_end;

    always_comb begin
        cfg         = ELEM_CFG[elem_q];
        elem_nxt    = next_elem(elem_q);
        elem_end    = cfg.down ? (addr_q == '0) : (addr_q == ADDR_MAX);
        elem_d      = elem_q;
        addr_d      = addr_q;
        cmp_valid_d = run_i && cfg.rd;
        cmp_exp_d   = cfg.exp_inv ? ~DATA_BG : DATA_BG;
        cmp_addr_d  = addr_q;
        if (go_i) begin
            elem_d      = EL_M0;
            addr_d      = '0;
            cmp_valid_d = 1'b0;
        end else if (run_i) begin
            // Roll straight into the next element so there is no idle cycle.
            if (elem_end) begin
                elem_d = elem_nxt;
                addr_d = ELEM_CFG[elem_nxt].down ? ADDR_MAX : '0;
            end else begin
                addr_d = cfg.down ? addr_q - 1'b1 : addr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            elem_q      <= EL_M0;
            addr_q      <= '0;
            cmp_valid_q <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
        end else begin
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_exp_q   <= cmp_exp_d;
            cmp_addr_q  <= cmp_addr_d;
        end
    end

    assign last_o          = (elem_q == EL_M5) && elem_end;
    assign cmp_valid_o     = cmp_valid_q;
    assign cmp_exp_o       = cmp_exp_q;
    assign cmp_addr_o      = cmp_addr_q;
    assign ram.ram_we      = run_i && cfg.wr;
    assign ram.ram_address = addr_q;
    assign ram.ram_d       = run_i ? (cfg.wr_inv ? ~DATA_BG : DATA_BG) : '0;

endmodule

// File: rtl/ram_march_bist.sv
// March C- BIST initiator for a single-port synchronous RAM: FSM, read compare
// and result registers. Define BIST_STOP_ON_FAIL_EN to end the test at the first mismatch.
module ram_march_bist
    import ram_bist_pkg::*;
#(
    parameter int                    Data_width = 32,
    parameter int                    Addr_width = 7,
    parameter logic [Data_width-1:0] DATA_BG    = '0,
    parameter int                    CNT_width  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [Addr_width-1:0] fail_addr,
    output logic [Data_width-1:0] fail_data,
    output logic [CNT_width-1:0]  fail_count,
    ram_march_bist_if.master      ram
);

    localparam logic [CNT_width-1:0] CNT_MAX = '1;

    bist_state_e           state_q;
    logic                  busy_q, done_q, pass_q;
    logic [Addr_width-1:0] fail_addr_q;
    logic [Data_width-1:0] fail_data_q;
    logic [CNT_width-1:0]  fail_count_q;

    logic                  accept, run, last;
    logic                  cmp_valid, mismatch;
    logic [Data_width-1:0] cmp_exp;
    logic [Addr_width-1:0] cmp_addr;

    assign accept   = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign run      = (state_q == ST_RUN);
    // A compare still in flight after leaving RUN/DRAIN belongs to an aborted run.
    assign mismatch = cmp_valid && (state_q == ST_RUN || state_q == ST_DRAIN)
                      && (ram.ram_q != cmp_exp);

    ram_bist_march_seq #(
        .Data_width (Data_width),
        .Addr_width (Addr_width),
        .DATA_BG    (DATA_BG)
    ) u_seq (
        .clk         (clk),
        .rst         (rst),
        .go_i        (accept),
        .run_i       (run),
        .last_o      (last),
        .cmp_valid_o (cmp_valid),
        .cmp_exp_o   (cmp_exp),
        .cmp_addr_o  (cmp_addr),
        .ram         (ram)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_addr_q  <= '0;
            fail_data_q  <= '0;
            fail_count_q <= '0;
        end else begin
            if (mismatch) begin
                if (fail_count_q != CNT_MAX) fail_count_q <= fail_count_q + 1'b1;
                if (fail_count_q == '0) begin
                    fail_addr_q <= cmp_addr;
                    fail_data_q <= ram.ram_q;
                end
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q      <= ST_RUN;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        fail_addr_q  <= '0;
                        fail_data_q  <= '0;
                        fail_count_q <= '0;
                    end
                end
                ST_RUN: begin
`ifdef BIST_STOP_ON_FAIL_EN
                    if (mismatch) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= 1'b0;
                    end else if (last) begin
                        state_q <= ST_DRAIN;
                    end
`else
                    if (last) state_q <= ST_DRAIN;
`endif
                end
                ST_DRAIN: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (fail_count_q == '0) && !mismatch;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_addr  = fail_addr_q;
    assign fail_data  = fail_data_q;
    assign fail_count = fail_count_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// Self-checking bench for ram_march_bist against a 128x32 RAM model with an
// optional single stuck-at bit and a behavioural March C- reference.
module tb_ram_march_bist;

    localparam logic [31:0] BG = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, pass;
    logic [6:0]  fail_addr;
    logic [31:0] fail_data;
    logic [15:0] fail_count;

    bit          f_en;
    int          f_addr, f_bit;
    bit          f_val;
    logic [31:0] mem [128];

    int n_checks = 0;
    int n_fail   = 0;

    ram_march_bist_if #(.Data_width(32), .Addr_width(7)) ram_if ();

    ram_march_bist #(.Data_width(32), .Addr_width(7), .DATA_BG(32'h0), .CNT_width(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_addr  (fail_addr),
        .fail_data  (fail_data),
        .fail_count (fail_count),
        .ram        (ram_if)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] apply_fault(input int a, input logic [31:0] w);
        logic [31:0] r;
        r = w;
        if (f_en && a == f_addr) r[f_bit] = f_val;
        return r;
    endfunction

    // Read-before-write RAM with registered output.
    always @(posedge clk) begin
        ram_if.ram_q <= apply_fault(int'(ram_if.ram_address), mem[ram_if.ram_address]);
        if (ram_if.ram_we)
            mem[ram_if.ram_address] <= apply_fault(int'(ram_if.ram_address), ram_if.ram_d);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Whole-algorithm reference: walk the six elements over an array copy of the RAM.
    task automatic model_march(output int cnt, output int faddr, output logic [31:0] fdata,
                               output int first_op);
        logic [31:0] m [128];
        logic [31:0] rd, expw;
        int a;
        cnt = 0; faddr = 0; fdata = 0; first_op = -1;
        for (int e = 0; e < 6; e++) begin
            for (int j = 0; j < 128; j++) begin
                a = (e >= 3) ? 127 - j : j;
                if (e > 0) begin
                    rd   = apply_fault(a, m[a]);
                    expw = (e == 2 || e == 4) ? ~BG : BG;
                    if (rd !== expw) begin
                        if (cnt == 0) begin
                            faddr = a; fdata = rd; first_op = e * 128 + j;
                        end
                        cnt++;
                    end
                end
                if (e < 5) m[a] = apply_fault(a, (e == 1 || e == 3) ? ~BG : BG);
            end
        end
    endtask

    function automatic int adj_cnt(input int c);
`ifdef BIST_STOP_ON_FAIL_EN
        return (c > 0) ? 1 : 0;
`else
        return c;
`endif
    endfunction

    // Expected RAM port activity for operation k of a run.
    function automatic int op_err(input int k);
        int e, j, a;
        logic we_e;
        logic [31:0] d_e;
        if (k >= 768) return (ram_if.ram_we !== 1'b0) ? 1 : 0;
        e = k / 128; j = k % 128;
        a = (e >= 3) ? 127 - j : j;
        we_e = (e < 5);
        d_e  = (e == 1 || e == 3) ? ~BG : BG;
        if (ram_if.ram_we !== we_e || ram_if.ram_address !== a[6:0]) return 1;
        if (we_e && ram_if.ram_d !== d_e) return 1;
        return 0;
    endfunction

    task automatic run_bist(input string tag, input bit repulse, input logic exp_pass,
                            input int exp_cnt, input int exp_addr, input logic [31:0] exp_data);
        int n, perr, exp_edge, mcnt, maddr, mop;
        logic [31:0] mdata;
        model_march(mcnt, maddr, mdata, mop);
        exp_edge = 769;
`ifdef BIST_STOP_ON_FAIL_EN
        if (mop >= 0) exp_edge = mop + 2;
`endif
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check({tag, " busy_after_start"}, busy, 1'b1);
        n = 0; perr = 0;
        while (!done && n < 2000) begin
            if (busy) perr += op_err(n);
            start = (repulse && (n == 10 || n == 500));
            @(posedge clk); n++; #1;
        end
        start = 1'b0;
        check({tag, " done_edge"}, n, exp_edge);
        check({tag, " protocol"}, perr, 0);
        check({tag, " pass"}, pass, exp_pass);
        check({tag, " fail_count"}, fail_count, adj_cnt(exp_cnt));
        check({tag, " fail_addr"}, fail_addr, exp_addr);
        check({tag, " fail_data"}, fail_data, exp_data);
        repeat (3) @(posedge clk);
        #1;
        check({tag, " done_held"}, {busy, done, ram_if.ram_we}, 3'b010);
    endtask

    typedef struct {
        bit          f_en;
        int          f_addr;
        int          f_bit;
        bit          f_val;
        logic        exp_pass;
        int          exp_cnt;
        int          exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int mcnt, maddr, mop, bad;
        logic [31:0] mdata;

        vecs[0] = '{0, 0,    0,  0, 1'b1, 0, 0,    32'h0000_0000};
        vecs[1] = '{1, 'h2A, 5,  1, 1'b0, 3, 'h2A, 32'h0000_0020};
        vecs[2] = '{1, 'h10, 0,  0, 1'b0, 2, 'h10, 32'hFFFF_FFFE};
        vecs[3] = '{1, 'h00, 31, 1, 1'b0, 3, 'h00, 32'h8000_0000};
        vecs[4] = '{1, 'h7F, 7,  0, 1'b0, 2, 'h7F, 32'hFFFF_FF7F};

        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        f_en = 0; f_addr = 0; f_bit = 0; f_val = 0;
        rst = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset pass", pass, 1'b0);
        check("reset fail_addr", fail_addr, 7'h0);
        check("reset fail_data", fail_data, 32'h0);
        check("reset fail_count", fail_count, 16'h0);
        check("reset ram_port", {ram_if.ram_we, ram_if.ram_address, ram_if.ram_d}, 40'h0);

        @(negedge clk) start = 1'b1;
        @(posedge clk); #1;
        check("start_with_rst busy", busy, 1'b0);
        @(negedge clk) begin start = 1'b0; rst = 1'b0; end

        for (int i = 0; i < 5; i++) begin
            f_en = vecs[i].f_en; f_addr = vecs[i].f_addr;
            f_bit = vecs[i].f_bit; f_val = vecs[i].f_val;
            run_bist($sformatf("vec%0d", i), 0, vecs[i].exp_pass, vecs[i].exp_cnt,
                     vecs[i].exp_addr, vecs[i].exp_data);
            if (i == 0) begin
                bad = 0;
                for (int a = 0; a < 128; a++) if (mem[a] !== BG) bad++;
                check("vec0 ram_final_background", bad, 0);
            end
        end

        for (int r = 0; r < 6; r++) begin
            f_en   = ($urandom_range(0, 3) != 0);
            f_addr = $urandom_range(0, 127);
            f_bit  = $urandom_range(0, 31);
            f_val  = $urandom_range(0, 1);
            model_march(mcnt, maddr, mdata, mop);
            run_bist($sformatf("rand%0d", r), 0, (mcnt == 0), mcnt, maddr, mdata);
        end

        f_en = 0;
        run_bist("repulse", 1, 1'b1, 0, 0, 32'h0);

        f_en = 1; f_addr = 'h2A; f_bit = 5; f_val = 1;
        @(negedge clk) start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("midrun partial_fail_seen", (fail_count != 0), 1'b1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("midrun_rst state", {busy, done, ram_if.ram_we}, 3'b000);
        check("midrun_rst fail_count", fail_count, 16'h0);
        @(negedge clk) rst = 1'b0;
        f_en = 0;
        run_bist("after_rst", 0, 1'b1, 0, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_march_bist.md
Name: ram_march_bist

Overview:
- Built-in self-test initiator that drives the port of the team's single-port synchronous RAM (RAM128x32 class) from the requester side.
- On `start`, it runs a March C- sequence over every address and compares each read word against the expected background.
- It reports pass/fail, the first failing address and word, and a fail count.
- It sits between the RAM instance and a test/config register block; the RAM's normal requester is muxed out while `busy` is high (mux is outside this block).

Parameters:
- Data_width, 32, RAM word width in bits.
- Addr_width, 7, RAM address width; DEPTH = 2**Addr_width.
- DATA_BG, all-zeros, data background "0"; "1" is its bitwise complement.
- CNT_width, 16, width of `fail_count`.

Ports:
- clk  in  1  rising-edge clock, shared with the RAM.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a test; honoured only in IDLE or DONE.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  high in DONE; held until the next accepted start or reset.
- pass  out  1  valid while done; 1 when fail_count == 0.
- fail_addr  out  Addr_width  address of the first mismatch.
- fail_data  out  Data_width  word read at the first mismatch.
- fail_count  out  CNT_width  number of mismatching reads, saturating.
- ram_we  out  1  RAM write enable.
- ram_address  out  Addr_width  RAM address.
- ram_d  out  Data_width  RAM write data.
- ram_q  in  Data_width  RAM read data, registered in the RAM, valid 1 cycle after its address.

Behaviour:
- Reset values:
  - State IDLE; busy, done, pass = 0; fail_addr, fail_data, fail_count = 0.
  - ram_we = 0, ram_address = 0, ram_d = 0.
- RAM contract: the RAM reads before it writes. With ram_we = 1, ram_q on the next cycle returns the OLD word. Each read-then-write March operation ("rX,wY") is therefore issued as one cycle, so every element costs exactly 1 cycle per address.
- Elements, in order, with B = DATA_BG and ~B its complement:
  - M0: up, w(B).
  - M1: up, r(B) then w(~B).
  - M2: up, r(~B) then w(B).
  - M3: down, r(B) then w(~B).
  - M4: down, r(~B) then w(B).
  - M5: down, r(B), with ram_we = 0.
- Addressing: "up" runs 0 to DEPTH-1 and "down" runs DEPTH-1 to 0. The address counter wraps into the next element with no idle cycle.
- FSM states:
  - IDLE, on start: go to RUN and clear all result outputs.
  - RUN: one operation per cycle. After the last address of M5, go to DRAIN.
  - DRAIN: one cycle to compare the final read, then go to DONE.
  - DONE, on start: go to RUN and clear all result outputs.
- ram_* drive: combinational from the registered element and address counters. ram_we = 0 outside RUN and during M5.
- Compare pipeline:
  - Each read element registers cmp_valid, the expected word and the address.
  - On the following edge ram_q is compared against the expected word.
  - On a mismatch, fail_count increments (holding at its maximum). The first mismatch only latches fail_addr and fail_data.
- Timing: with the start-sampling edge as edge 0, done rises after edge 6*DEPTH+1. That is edge 769 at default parameters.
- Boundaries:
  - start while busy: ignored.
  - start and rst together: rst wins.
  - rst mid-run: IDLE at the next edge, ram_we = 0, partial results cleared. RAM contents are left undefined.
  - A compare and the next issue occur in the same cycle; there is no stall.

Optional Feature:
- Macro: BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch moves the FSM directly to DONE at that edge and fail_count = 1. The operation issued in that same cycle still completes at the RAM; no further operations are issued.
- Undefined: the full sequence always runs and all mismatches are counted.

Decomposition:
- Package ram_bist_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the element enum (M0..M5);
  - a per-element constant table: direction, read flag, write flag, expected-is-complement, write-is-complement.
- One sub-module, ram_bist_march_seq: element/address counters and the ram_* drive, exporting cmp_valid, expected word and address.
- The top level holds the FSM, the compare logic and the result registers.

Test Plan:
- Fault-free 128x32 RAM model, start pulse → busy for 769 cycles; done=1, pass=1, fail_count=0. RAM ends holding DATA_BG at all addresses.
- Bit 5 of address 0x2A stuck-at-1 → pass=0, fail_addr=0x2A, fail_data=0x00000020, fail_count=3 (failing reads in M1, M3 and M5).
- Same fault with BIST_STOP_ON_FAIL_EN → done asserts in M1, one cycle after the read of 0x2A; fail_count=1, fail_addr=0x2A.
- Protocol trace on a fault-free RAM, 8 cycles before the M0→M1 transition → addresses 0x7F in M0 then 0x00 in M1; ram_we=1 in M0 and M1; ram_we=0 throughout M5; addresses descend from 0x7F in M3.
- rst asserted at cycle 300 of a run → next cycle busy=0, done=0, ram_we=0. A new start then completes a normal 769-cycle run with pass=1.
- start re-pulsed at cycles 10 and 500 of a run → ignored; done still rises at edge 769 after the original start.
